cc_velctrl: RTL and testbench
=============================

# cc_velctrl

Velocity controller for the alien-formation movement path. It sequences the 2:1 velocity multiplexer by driving its active-low select: `0` picks the slow input (IN1) and `1` picks the fast input (IN2). It also generates the matching one-cycle movement strobe. Speed is promoted from slow to fast after a configurable number of enemy kills. The block sits between game-control logic (start, pause, game over, kill events) and the velocity mux / formation mover.

## Interface

Parameters:
- `TICK_SLOW`, default 25_000_000: clock cycles per movement tick in slow mode. Must be ≥ 2.
- `TICK_FAST`, default 12_500_000: clock cycles per tick in fast mode. Must satisfy 2 ≤ `TICK_FAST` < `TICK_SLOW`.
- `KILLS_TO_FAST`, default 16: kills needed to promote to fast mode. Range 1..255.
- `CNT_W`, default 25: divider width. Must hold `TICK_SLOW`-1.

Ports:
- `CC_VELCTRL_CLOCK_50`  in  1  single system clock; all logic on its rising edge.
- `CC_VELCTRL_RESET_InHigh`  in  1  synchronous, active-high reset.
- `CC_VELCTRL_start_InHigh`  in  1  one-cycle pulse that starts or restarts a level.
- `CC_VELCTRL_pause_InHigh`  in  1  level signal; freezes movement while high.
- `CC_VELCTRL_kill_InHigh`  in  1  one-cycle pulse per enemy destroyed.
- `CC_VELCTRL_gameover_InHigh`  in  1  pulse or level; halts movement.
- `CC_VELCTRL_select_OutLow`  out  1  registered; drives the velocity mux select (0 = slow/IN1, 1 = fast/IN2).
- `CC_VELCTRL_tick_Out`  out  1  registered one-cycle movement strobe.
- `CC_VELCTRL_state_Out`  out  2  current state encoding.

## Operation

- States: IDLE=0, SLOW=1, FAST=2, HALT=3.
- IDLE:
  - select=0; no ticks.
  - `start` → SLOW. Divider and kill counter cleared.
- SLOW:
  - Divider period is `TICK_SLOW`.
  - Each kill pulse, when not paused, increments the 8-bit kill counter. The counter saturates at 255.
  - On the edge where the counter reaches `KILLS_TO_FAST` → FAST. On that edge, divider cleared and select←1.
- FAST:
  - Divider period is `TICK_FAST`.
  - Kills are still counted (saturating) but have no effect.
- HALT:
  - No ticks; select←0; divider frozen at 0.
  - `start` → SLOW with divider and kills cleared.
- `gameover` in SLOW or FAST → HALT. `start` is ignored in SLOW and FAST.
- Priority within one cycle: reset > gameover > pause > kill/divider.
  - A gameover that coincides with a kill or divider wrap produces no tick and no promotion.
- Pause (SLOW/FAST only):
  - Divider holds its value; no tick is issued.
  - Kill pulses are ignored, not queued.
  - State is unchanged. Resuming continues from the held count.
- Divider:
  - `cnt` increments each active cycle.
  - At `cnt == period-1`: `cnt`←0 and tick←1 for the next cycle. Otherwise tick←0.
  - If a wrap coincides with promotion to FAST, the tick is still issued and `cnt`←0.

## Timing

- Reset values: state=IDLE, `CC_VELCTRL_select_OutLow`=0, `CC_VELCTRL_tick_Out`=0, `CC_VELCTRL_state_Out`=0, `cnt`=0, kills=0.
- Reset mid-operation dominates all inputs. Outputs show reset values in the cycle after the reset edge.
- All outputs are registered; there are no combinational input-to-output paths.
- Latencies:
  - `start` sampled at edge N → state=SLOW visible after edge N.
  - The first tick is high in the cycle after edge N+`TICK_SLOW`.
  - In steady state, ticks occur exactly `TICK_SLOW` (or `TICK_FAST`) cycles apart, each high for exactly one cycle.
  - Promotion: the kill reaching the threshold is sampled at edge M → select=1 and state=FAST after edge M. The first fast tick follows edge M+`TICK_FAST`.
  - Gameover sampled at edge G → state=HALT and select=0 after edge G. Tick is 0 from then on.

## Structure

- Package `cc_velctrl_pkg` holds:
  - the state encoding localparams (IDLE/SLOW/FAST/HALT, 2 bits);
  - the kill-counter width (8).
- One sub-module, `cc_velctrl_divider`:
  - inputs: `CNT_W`-bit period, enable, clear;
  - output: registered tick.
- The top level contains the FSM, the kill counter, the period selection, and the select register.

## Test plan

All scenarios use `TICK_SLOW`=8, `TICK_FAST`=3, `KILLS_TO_FAST`=4.

- **Reset and idle:** after reset, hold all inputs low for 20 cycles → state=0, select=0, tick never high.
- **Slow ticking:** start pulse at edge 0 → state=1; tick high in the cycles after edges 8, 16, 24; tick low in every other cycle.
- **Promotion:**
  - Start, then 4 kill pulses spaced 2 cycles apart.
  - The 4th kill at edge M → after M: state=2, select=1.
  - Ticks then arrive every 3 cycles starting at M+3.
- **Pause:** in SLOW at `cnt`=5, assert pause for 10 cycles and pulse kill twice during the pause.
  - No tick during the pause; kill count unchanged.
  - After release, the next tick comes 3 cycles later.
- **Gameover collision:** in FAST, assert gameover in the same cycle as the divider wrap → no tick, state=3, select=0. A following start → state=1, kills=0.
- **Reset mid-level:** in FAST, assert reset for 1 cycle, then start → all outputs at reset values, then slow ticking every 8 cycles with select=0.

Source files
------------

// File: rtl/cc_velctrl_pkg.sv
// Shared definitions for the alien-formation velocity controller:
// state encoding and kill-counter width.
package cc_velctrl_pkg;

    localparam int KILL_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SLOW = 2'd1;
    localparam state_t ST_FAST = 2'd2;
    localparam state_t ST_HALT = 2'd3;

    localparam logic [KILL_W-1:0] KILL_MAX = {KILL_W{1'b1}};

    // Saturating increment used by the kill counter.
    function automatic logic [KILL_W-1:0] kill_sat_inc(input logic [KILL_W-1:0] k);
        return (k == KILL_MAX) ? k : k + KILL_W'(1);
    endfunction

endpackage

// File: rtl/cc_velctrl_divider.sv
// Programmable tick divider: counts enabled cycles and emits a registered
// one-cycle tick on the cycle after the count reaches period-1.
module cc_velctrl_divider #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period,
    input  logic             en,
    input  logic             clr,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = en && (cnt == (period - CNT_W'(1)));

    // A clear does not cancel a wrap on the same edge: the tick still fires,
    // only the count restarts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            if (clr || wrap) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cc_velctrl.sv
// Velocity controller: drives the slow/fast mux select and the movement
// strobe, promoting to fast speed after a number of enemy kills.
module cc_velctrl
    import cc_velctrl_pkg::*;
#(
    parameter int TICK_SLOW     = 25_000_000,
    parameter int TICK_FAST     = 12_500_000,
    parameter int KILLS_TO_FAST = 16,
    parameter int CNT_W         = 25
) (
    input  logic       CC_VELCTRL_CLOCK_50,
    input  logic       CC_VELCTRL_RESET_InHigh,
    input  logic       CC_VELCTRL_start_InHigh,
    input  logic       CC_VELCTRL_pause_InHigh,
    input  logic       CC_VELCTRL_kill_InHigh,
    input  logic       CC_VELCTRL_gameover_InHigh,
    output logic       CC_VELCTRL_select_OutLow,
    output logic       CC_VELCTRL_tick_Out,
    output logic [1:0] CC_VELCTRL_state_Out
);

    localparam logic [CNT_W-1:0]  PERIOD_SLOW = CNT_W'(TICK_SLOW);
    localparam logic [CNT_W-1:0]  PERIOD_FAST = CNT_W'(TICK_FAST);
    localparam logic [KILL_W-1:0] KILL_TGT    = KILL_W'(KILLS_TO_FAST);

    logic clk;
    logic rst;
    assign clk = CC_VELCTRL_CLOCK_50;
    assign rst = CC_VELCTRL_RESET_InHigh;

    state_t            state;
    state_t            state_next;
    logic [KILL_W-1:0] kills;
    logic [KILL_W-1:0] kills_inc_val;
    logic              active;
    logic              launch;
    logic              kill_inc;
    logic              promote;
    logic              div_en;
    logic              div_clr;
    logic [CNT_W-1:0]  period;
    logic              select_q;

    // Gameover outranks pause, which outranks kills and divider activity.
    assign active        = (state == ST_SLOW) || (state == ST_FAST);
    assign launch        = CC_VELCTRL_start_InHigh && !active;
    assign kill_inc      = active && CC_VELCTRL_kill_InHigh
                           && !CC_VELCTRL_pause_InHigh && !CC_VELCTRL_gameover_InHigh;
    assign kills_inc_val = kill_sat_inc(kills);
    assign promote       = (state == ST_SLOW) && kill_inc
                           && (kills != KILL_MAX) && (kills_inc_val == KILL_TGT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (CC_VELCTRL_start_InHigh) state_next = ST_SLOW;
            end
            ST_SLOW: begin
                if (CC_VELCTRL_gameover_InHigh) state_next = ST_HALT;
                else if (promote)               state_next = ST_FAST;
            end
            ST_FAST: begin
                if (CC_VELCTRL_gameover_InHigh) state_next = ST_HALT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        div_en  = active && !CC_VELCTRL_gameover_InHigh && !CC_VELCTRL_pause_InHigh;
        div_clr = launch || promote || (active && CC_VELCTRL_gameover_InHigh);
        period  = (state == ST_FAST) ? PERIOD_FAST : PERIOD_SLOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kills <= '0;
        end else if (launch) begin
            kills <= '0;
        end else if (kill_inc) begin
            kills <= kills_inc_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            select_q <= 1'b0;
        end else begin
            select_q <= (state_next == ST_FAST);
        end
    end

    cc_velctrl_divider #(
        .CNT_W (CNT_W)
    ) u_divider (
        .clk    (clk),
        .rst    (rst),
        .period (period),
        .en     (div_en),
        .clr    (div_clr),
        .tick   (CC_VELCTRL_tick_Out)
    );

    assign CC_VELCTRL_select_OutLow = select_q;
    assign CC_VELCTRL_state_Out     = state;

endmodule

// File: tb/tb_cc_velctrl.sv
// Bench for cc_velctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a behavioural model through an expected queue.
module tb_cc_velctrl;

    localparam int TS = 8;
    localparam int TF = 3;
    localparam int KF = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic       kill;
    logic       gameover;
    logic       select_lo;
    logic       tick;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    // Behavioural model state: mode, elapsed active cycles since last wrap, kill tally.
    logic [1:0] m_state = 2'd0;
    int         m_cnt   = 0;
    int         m_kills = 0;
    logic       m_sel   = 1'b0;
    logic       m_tick  = 1'b0;

    cc_velctrl #(
        .TICK_SLOW     (TS),
        .TICK_FAST     (TF),
        .KILLS_TO_FAST (KF),
        .CNT_W         (4)
    ) dut (
        .CC_VELCTRL_CLOCK_50        (clk),
        .CC_VELCTRL_RESET_InHigh    (rst),
        .CC_VELCTRL_start_InHigh    (start),
        .CC_VELCTRL_pause_InHigh    (pause),
        .CC_VELCTRL_kill_InHigh     (kill),
        .CC_VELCTRL_gameover_InHigh (gameover),
        .CC_VELCTRL_select_OutLow   (select_lo),
        .CC_VELCTRL_tick_Out        (tick),
        .CC_VELCTRL_state_Out       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model, evaluated on every active edge
    always @(posedge clk) begin
        int per;
        if (rst) begin
            m_state = 2'd0; m_cnt = 0; m_kills = 0; m_tick = 1'b0;
        end else if (m_state == 2'd0 || m_state == 2'd3) begin
            m_tick = 1'b0;
            if (start) begin
                m_state = 2'd1; m_cnt = 0; m_kills = 0;
            end
        end else if (gameover) begin
            m_state = 2'd3; m_cnt = 0; m_tick = 1'b0;
        end else if (pause) begin
            m_tick = 1'b0;
        end else begin
            per    = (m_state == 2'd1) ? TS : TF;
            m_tick = (m_cnt == per - 1);
            m_cnt  = m_tick ? 0 : m_cnt + 1;
            if (kill && m_kills < 255) m_kills = m_kills + 1;
            if (m_state == 2'd1 && kill && m_kills == KF) begin
                m_state = 2'd2; m_cnt = 0;
            end
        end
        m_sel = (m_state == 2'd2);
        exp_q.push_back({m_state, m_sel, m_tick});
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // monitor: outputs are always presented, so one expected entry per cycle
    always @(negedge clk) begin
        logic [3:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",  state,            e[3:2]);
            check("select", {1'b0, select_lo}, {1'b0, e[1]});
            check("tick",   {1'b0, tick},      {1'b0, e[0]});
        end
    end

    // driver: inputs change on the falling edge, held through the next rising edge
    task automatic step(input logic s, input logic k, input logic p,
                        input logic g, input logic r);
        start = s; kill = k; pause = p; gameover = g; rst = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic wait_cnt(input logic [1:0] st, input int c);
        int guard;
        guard = 0;
        while (!(m_state == st && m_cnt == c) && guard < 40) begin
            step(0, 0, 0, 0, 0);
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL wait_cnt: state %0d cnt %0d never reached (got %0d/%0d)",
                     st, c, m_state, m_cnt);
        end
    endtask

    task automatic promote;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < KF; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        logic s, k, p, g, r;
        start = 0; kill = 0; pause = 0; gameover = 0; rst = 1;
        @(negedge clk);
        step(0, 0, 0, 0, 1);

        // reset and idle
        idle(20);
        // slow ticking
        step(1, 0, 0, 0, 0);
        idle(30);

        // promotion, then gameover colliding with a fast wrap
        step(0, 0, 0, 1, 0);
        promote();
        idle(10);
        wait_cnt(2'd2, TF - 1);
        step(0, 0, 0, 1, 0);
        idle(5);
        step(1, 0, 0, 0, 0);
        idle(12);

        // pause at cnt=5 with kills ignored during pause
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        wait_cnt(2'd1, 5);
        for (int i = 0; i < 10; i++) step(0, (i == 2 || i == 6), 1, 0, 0);
        idle(12);
        // kills ignored while paused: four fresh kills are still needed
        for (int i = 0; i < KF; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        idle(10);

        // reset mid-level in FAST
        step(0, 0, 0, 1, 0);
        promote();
        idle(4);
        step(0, 0, 0, 0, 1);
        idle(3);
        step(1, 0, 0, 0, 0);
        idle(30);

        // random traffic
        p = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            s = ($urandom_range(0, 99) < 4);
            k = ($urandom_range(0, 99) < 20);
            g = ($urandom_range(0, 199) < 2);
            r = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 99) < 6) p = ~p;
            step(s, k, p, g, r);
        end

        idle(3);
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected at most 1", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
